// File: rtl/prt_dptx_skew_ctl_pkg.sv
// Shared TX skew-control types and helpers.
// State encoding, drain length, lane-count legality and lane/skew masks.
package prt_dptx_skew_ctl_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_WAIT_SAFE,
        ST_DRAIN,
        ST_APPLY,
        ST_SETTLE
    } state_t;

    // Deepest lane delay plus one symbol group.
    function automatic int drain_len(input int spl);
        return (spl == 4) ? 3 : 4;
    endfunction

    function automatic logic lanes_legal(input logic [2:0] n);
        return (n == 3'd1) || (n == 3'd2) || (n == 3'd4);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] n);
        logic [3:0] m;
        case (n)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Lane 0 is the skew reference and never gets a delay stage.
    function automatic logic [3:0] skew_mask(
        input logic       en,
        input logic [3:0] lm
    );
        return {lm[3:1] & {3{en}}, 1'b0};
    endfunction

endpackage

// File: rtl/prt_dptx_skew_ctl_tmr.sv
// Loadable down-counter with zero flag; used for timeout and drain counts.
// Ports: CLK_IN, RST_IN (sync low), LOAD_IN/VAL_IN load, DEC_IN step, ZERO_OUT.
module prt_dptx_skew_ctl_tmr
    import prt_dptx_skew_ctl_pkg::*;
#(
    parameter int P_W = 16
) (
    input  logic           CLK_IN,
    input  logic           RST_IN,
    input  logic           LOAD_IN,
    input  logic [P_W-1:0] VAL_IN,
    input  logic           DEC_IN,
    output logic           ZERO_OUT
);

    logic [P_W-1:0] r_cnt;

    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            r_cnt <= '0;
        end else if (LOAD_IN) begin
            r_cnt <= VAL_IN;
        end else if (DEC_IN && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign ZERO_OUT = (r_cnt == '0);

endmodule

// File: rtl/prt_dptx_skew_ctl.sv
// Runtime controller applying skew/lane-count updates in a safe link window.
// Ports: CFG_* request, LNK_IDLE_IN window; SKEW/LANE enables, FLUSH/BUSY/DONE/ERR.
module prt_dptx_skew_ctl
    import prt_dptx_skew_ctl_pkg::*;
#(
    parameter int P_SPL      = 2,
    parameter int P_TIMEOUT  = 65535,
    parameter bit P_SKEW_RST = 1'b1
) (
    input  logic       CLK_IN,
    input  logic       RST_IN,
    input  logic       CFG_SKEW_EN_IN,
    input  logic [2:0] CFG_LANES_IN,
    input  logic       CFG_UPD_IN,
    input  logic       LNK_IDLE_IN,
    output logic [3:0] SKEW_EN_OUT,
    output logic [3:0] LANE_EN_OUT,
    output logic       FLUSH_OUT,
    output logic       BUSY_OUT,
    output logic       DONE_OUT,
    output logic       ERR_OUT
);

    localparam int C_TW0 = $clog2(P_TIMEOUT + 1);
    localparam int C_TW  = (C_TW0 > 3) ? C_TW0 : 3;

    localparam logic [C_TW-1:0] C_TMO = C_TW'(P_TIMEOUT);
    localparam logic [C_TW-1:0] C_DRN = C_TW'(drain_len(P_SPL) - 1);

    localparam logic [3:0] C_SKEW_RST = {{3{P_SKEW_RST}}, 1'b0};

    state_t r_state;
    state_t w_nxt;

    logic       r_pend;
    logic       r_shd_skew;
    logic [2:0] r_shd_lanes;
    logic [3:0] r_lane_en;
    logic [3:0] r_skew_en;
    logic       r_flush;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic       r_err_hold;

    logic            w_upd_ok;
    logic            w_upd_bad;
    logic            w_ld;
    logic [C_TW-1:0] w_ld_val;
    logic            w_dec;
    logic            w_tzero;
    logic            w_apply;
    logic            w_done;
    logic            w_tmo;
    logic            w_pend_nxt;
    logic            w_err_any;
    logic [3:0]      w_shd_mask;

    assign w_upd_ok   = CFG_UPD_IN & lanes_legal(CFG_LANES_IN);
    assign w_upd_bad  = CFG_UPD_IN & ~lanes_legal(CFG_LANES_IN);
    assign w_err_any  = w_upd_bad | w_tmo | r_err_hold;
    assign w_shd_mask = lane_mask(r_shd_lanes);

    prt_dptx_skew_ctl_tmr #(
        .P_W (C_TW)
    ) u_tmr (
        .CLK_IN   (CLK_IN),
        .RST_IN   (RST_IN),
        .LOAD_IN  (w_ld),
        .VAL_IN   (w_ld_val),
        .DEC_IN   (w_dec),
        .ZERO_OUT (w_tzero)
    );

    always_comb begin
        w_nxt      = r_state;
        w_ld       = 1'b0;
        w_ld_val   = '0;
        w_dec      = 1'b0;
        w_apply    = 1'b0;
        w_done     = 1'b0;
        w_tmo      = 1'b0;
        w_pend_nxt = r_pend;
        if ((r_state != ST_RUN) && w_upd_ok) begin
            w_pend_nxt = 1'b1;
        end
        unique case (r_state)
            ST_RUN: begin
                if (w_upd_ok) begin
                    w_nxt    = ST_WAIT_SAFE;
                    w_ld     = 1'b1;
                    w_ld_val = C_TMO;
                end
            end
            ST_WAIT_SAFE: begin
                if (LNK_IDLE_IN) begin
                    w_nxt    = ST_DRAIN;
                    w_ld     = 1'b1;
                    w_ld_val = C_DRN;
                end else if (w_tzero) begin
                    w_nxt      = ST_RUN;
                    w_tmo      = 1'b1;
                    w_pend_nxt = 1'b0;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_tzero) begin
                    w_nxt = ST_APPLY;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_APPLY: begin
                w_nxt    = ST_SETTLE;
                w_apply  = 1'b1;
                w_ld     = 1'b1;
                w_ld_val = C_DRN;
            end
            ST_SETTLE: begin
                if (w_tzero) begin
                    w_done = 1'b1;
                    // A request arriving on this last cycle counts as pending.
                    if (r_pend || w_upd_ok) begin
                        w_nxt      = ST_WAIT_SAFE;
                        w_ld       = 1'b1;
                        w_ld_val   = C_TMO;
                        w_pend_nxt = 1'b0;
                    end else begin
                        w_nxt = ST_RUN;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: begin
                w_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            r_state     <= ST_RUN;
            r_pend      <= 1'b0;
            r_shd_skew  <= 1'b0;
            r_shd_lanes <= 3'd0;
            r_lane_en   <= 4'b1111;
            r_skew_en   <= C_SKEW_RST;
            r_flush     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_hold  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_pend  <= w_pend_nxt;
            if (w_upd_ok) begin
                r_shd_skew  <= CFG_SKEW_EN_IN;
                r_shd_lanes <= CFG_LANES_IN;
            end
            if (w_apply) begin
                r_lane_en <= w_shd_mask;
                r_skew_en <= skew_mask(r_shd_skew, w_shd_mask);
            end
            r_flush <= (w_nxt == ST_DRAIN) ||
                       (w_nxt == ST_APPLY) ||
                       (w_nxt == ST_SETTLE);
            r_busy  <= (w_nxt != ST_RUN);
            r_done  <= w_done;
            // ERR yields to DONE and is pushed one cycle later.
            r_err      <= w_err_any & ~w_done;
            r_err_hold <= w_err_any & w_done;
        end
    end

    assign SKEW_EN_OUT = r_skew_en;
    assign LANE_EN_OUT = r_lane_en;
    assign FLUSH_OUT   = r_flush;
    assign BUSY_OUT    = r_busy;
    assign DONE_OUT    = r_done;
    assign ERR_OUT     = r_err;

endmodule
